fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Read-side consumer for the FIFO memory controller. It monitors the FIFO empty flag and pops one word at a time with a single-cycle read strobe. It captures each word on the cycle after the strobe and serializes it onto an asynchronous UART-style line: start bit, LSB-first data, stop bit(s). It sits between the FIFO storage and the chip's serial transmit pin.

Parameters:
DATA_W, 8, data word width in bits; legal range 5..9.
CLKS_PER_BIT, 16, clk cycles per serial bit; minimum 2.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  reset, asynchronous, active-high.
tx_en  input  1  enable; when low, no new frame starts.
fifo_emp  input  1  FIFO empty flag; high means no word is available.
fifo_rd  output  1  single-cycle read strobe to the FIFO controller.
fifo_data  input  DATA_W  FIFO read data; valid the cycle after fifo_rd.
tx  output  1  serial line; idle level is high.
busy  output  1  high whenever state is not IDLE.
byte_done  output  1  one-cycle pulse on the last cycle of each frame.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; tx=1, fifo_rd=0, busy=0, byte_done=0.
  - Shift register, baud counter and bit counter all cleared.
- All outputs are registered, or decoded from registered state only. There are no combinational paths from inputs to outputs.
- FSM states and transitions:
  - IDLE: tx=1. If tx_en=1 and fifo_emp=0, go to REQ; otherwise stay.
  - REQ (1 cycle): fifo_rd=1, tx=1. Always go to LOAD.
  - LOAD (1 cycle): capture fifo_data into the shift register, tx=1. Clear the baud counter and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0]. Every CLKS_PER_BIT cycles, shift right one bit and increment the bit counter. After DATA_W bits, go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
    - byte_done=1 on the final STOP cycle.
    - On exit, go to REQ if tx_en=1 and fifo_emp=0; otherwise go to IDLE.
- Baud counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Bit counter width is clog2(DATA_W+1).
- Frame length, from the first START cycle through the last STOP cycle, is exactly (1+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles.
- Latency: with fifo_emp falling while in IDLE, fifo_rd asserts on the next cycle and tx falls 2 cycles after fifo_rd.
- Back-to-back frames: exactly 2 idle-high cycles (REQ, LOAD) separate the last STOP cycle from the next START cycle.
- fifo_emp and tx_en are sampled only in IDLE and on the STOP exit cycle. Changes at any other time do not affect the frame in flight.
- fifo_rd is never asserted while fifo_emp=1 at the sampling cycle. At most one fifo_rd is issued per frame.
- tx_en deasserted mid-frame: the current frame completes unchanged, then the FSM returns to IDLE.
- Reset mid-frame: tx returns to 1 immediately and the partial byte is discarded. The FIFO word is not re-read (it was already popped).
- fifo_data is ignored in every state except LOAD.

Test Plan:
(All scenarios use DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1.)
1. Assert rst with random inputs -> tx=1, fifo_rd=0, busy=0, byte_done=0 in the same cycle; these values hold while rst=1.
2. fifo_emp=1, tx_en=1 for 200 cycles -> fifo_rd never asserts, tx stays 1, busy stays 0.
3. One word 0xA5, fifo_emp falls once:
   - fifo_rd pulses for exactly 1 cycle.
   - tx shows 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles.
   - byte_done pulses on frame cycle 40.
4. Words 0x00 then 0xFF with fifo_emp held low -> two frames with exactly 2 idle-high tx cycles between them; 2 fifo_rd pulses total.
5. tx_en dropped during DATA of the first of 3 queued words -> first frame completes bit-exact, then IDLE with no further fifo_rd. Raising tx_en resumes with the second word.
6. rst pulsed during the 3rd data bit of 0x3C -> tx=1 immediately. After rst releases with fifo_emp=0, a fresh REQ/LOAD occurs and the next word transmits correctly.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer: pops one word per frame and shifts it out as an
// asynchronous serial frame (start bit, LSB-first data, STOP_BITS stop bits).
module fifo_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_emp,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   shift;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic                baud_end;
  logic                start_ok;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign start_ok = tx_en && !fifo_emp;

  // Outputs decode registered state only, so reset forces them at once.
  assign fifo_rd   = (state == REQ);
  assign busy      = (state != IDLE);
  assign tx        = (state == START) ? 1'b0 :
                     (state == DATA)  ? shift[0] : 1'b1;
  assign byte_done = (state == STOP) && baud_end && (bit_cnt == STOP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_ok) state <= REQ;
        end
        REQ: begin
          state <= LOAD;
        end
        LOAD: begin
          shift    <= fifo_data;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          state    <= START;
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[DATA_W-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          // bit_cnt reused to count stop bits when STOP_BITS is 2.
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= start_ok ? REQ : IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: reset/latency vector table, directed frame
// sequences and randomized traffic against a frame-level waveform model.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int SB  = 1;

  logic          clk;
  logic          rst;
  logic          tx_en;
  logic          fifo_emp;
  logic          fifo_rd;
  logic [DW-1:0] fifo_data;
  logic          tx;
  logic          busy;
  logic          byte_done;

  fifo_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_emp(fifo_emp),
    .fifo_rd(fifo_rd), .fifo_data(fifo_data), .tx(tx), .busy(busy),
    .byte_done(byte_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_count = 0;

  // {tx, fifo_rd, busy, byte_done} expected per cycle
  logic [3:0]    wave[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] pend_word;
  logic          pend;
  logic          force_emp;

  typedef struct {
    logic       rst;
    logic       en;
    logic       emp;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Whole frame derived from the protocol: REQ, LOAD, start, data LSB-first, stops.
  function automatic void add_frame(input logic [DW-1:0] w);
    wave.push_back(4'b1110);
    wave.push_back(4'b1010);
    for (int b = 0; b < 1 + DW + SB; b++) begin
      logic v;
      v = (b == 0) ? 1'b0 : (b <= DW) ? w[b-1] : 1'b1;
      for (int c = 0; c < CPB; c++)
        wave.push_back({v, 1'b0, 1'b1, (b == DW + SB) && (c == CPB - 1)});
    end
  endfunction

  task automatic tick();
    logic [3:0] exp;
    logic [3:0] dummy;
    if (wave.size() > 0) dummy = wave.pop_front();
    if (rst) wave.delete();
    else if (wave.size() == 0 && tx_en && !fifo_emp) add_frame(fq[0]);
    @(posedge clk);
    #1;
    cyc++;
    exp = (wave.size() > 0) ? wave[0] : 4'b1000;
    check($sformatf("cycle%0d", cyc), {tx, fifo_rd, busy, byte_done}, exp);
    if (pend) begin
      fifo_data = pend_word;
      pend = 1'b0;
    end else begin
      fifo_data = DW'($urandom);
    end
    if (fifo_rd === 1'b1) begin
      if (fq.size() > 0) pend_word = fq.pop_front();
      pend = 1'b1;
      rd_count++;
    end
    fifo_emp = force_emp || (fq.size() == 0);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    fifo_emp = force_emp || (fq.size() == 0);
  endtask

  task automatic wait_start(input int max_cyc, output logic found);
    found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      tick();
      if (tx === 1'b0) found = 1'b1;
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    rst = v.rst;
    tx_en = v.en;
    fifo_emp = v.emp;
    fifo_data = DW'($urandom);
    @(posedge clk);
    #1;
    check($sformatf("vec%0d", idx), {tx, fifo_rd, busy, byte_done}, v.exp);
  endtask

  initial begin
    logic found;
    int t0, t1, t2, tr;

    rst = 1'b0;
    tx_en = 1'b0;
    fifo_emp = 1'b1;
    fifo_data = '0;
    pend = 1'b0;
    pend_word = '0;
    force_emp = 1'b0;

    // Asynchronous reset before any clock edge
    #3;
    rst = 1'b1;
    tx_en = 1'b1;
    fifo_emp = 1'b0;
    #1;
    check("rst_async", {tx, fifo_rd, busy, byte_done}, 4'b1000);

    vecs[0] = '{1'b1, 1'b1, 1'b0, 4'b1000};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 4'b1000};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 4'b1000};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 4'b1000};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 4'b1110};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 4'b1010};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 4'b0010};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 4'b1000};
    for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);

    // Hand over to the FIFO driver and waveform model
    wave.delete();
    fq.delete();
    fifo_emp = 1'b1;
    tx_en = 1'b1;
    tick();
    rst = 1'b0;

    // Empty FIFO with tx_en high: nothing happens
    force_emp = 1'b1;
    fifo_emp = 1'b1;
    rd_count = 0;
    for (int i = 0; i < 200; i++) tick();
    check("empty_no_rd", rd_count, 0);
    force_emp = 1'b0;

    // Single word 0xA5
    rd_count = 0;
    t0 = -1; t1 = -1; tr = -1;
    push_word(8'hA5);
    for (int i = 0; i < 80; i++) begin
      tick();
      if (fifo_rd === 1'b1 && tr < 0) tr = cyc;
      if (tx === 1'b0 && t0 < 0) t0 = cyc;
      if (byte_done === 1'b1 && t1 < 0) t1 = cyc;
    end
    check("a5_rd_count", rd_count, 1);
    check("a5_rd_to_start", t0 - tr, 2);
    check("a5_done_frame_cyc", t1 - t0 + 1, 40);

    // Back-to-back 0x00, 0xFF
    rd_count = 0;
    t1 = -1; t2 = -1;
    push_word(8'h00);
    push_word(8'hFF);
    for (int i = 0; i < 120; i++) begin
      tick();
      if (byte_done === 1'b1 && t1 < 0) t1 = cyc;
      if (t1 >= 0 && cyc > t1 && tx === 1'b0 && t2 < 0) t2 = cyc;
    end
    check("b2b_rd_count", rd_count, 2);
    check("b2b_gap", t2 - t1, 3);

    // tx_en dropped mid-frame
    push_word(8'h5A);
    push_word(8'hC3);
    push_word(8'h96);
    wait_start(50, found);
    check("en_start_seen", found, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    tx_en = 1'b0;
    rd_count = 0;
    for (int i = 0; i < 60; i++) tick();
    check("en_off_no_rd", rd_count, 0);
    check("en_off_idle", busy, 1'b0);
    tx_en = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    check("en_resume_rd", rd_count, 2);

    // Reset during data bit 2 of 0x3C
    push_word(8'h3C);
    push_word(8'h81);
    wait_start(50, found);
    check("rst_start_seen", found, 1'b1);
    for (int i = 0; i < 13; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    wave.delete();
    pend = 1'b0;
    tick();
    rst = 1'b0;
    rd_count = 0;
    for (int i = 0; i < 60; i++) tick();
    check("rst_fresh_rd", rd_count, 1);

    // Randomized traffic with tx_en toggling
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0 && fq.size() < 4) push_word(DW'($urandom));
      if ($urandom_range(0, 99) == 0) tx_en = ~tx_en;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
